// File: rtl/othello_pkg.sv
// =============================================================================
// Module  : othello_pkg
// Purpose : Shared board encodings, direction indices and board defaults.
//           FLIP_DIAG_EN selects whether the four diagonal directions exist.
// Revision: 1.0
// =============================================================================
`default_nettype none

package othello_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  typedef enum logic [2:0] {
    DIR_U  = 3'd0,
    DIR_D  = 3'd1,
    DIR_L  = 3'd2,
    DIR_R  = 3'd3,
    DIR_UL = 3'd4,
    DIR_UR = 3'd5,
    DIR_DL = 3'd6,
    DIR_DR = 3'd7
  } dir_e;

  // Mask bit of direction d is 7-d: U is the MSB, DR the LSB.
  localparam int DIR_BIT_U  = 7;
  localparam int DIR_BIT_D  = 6;
  localparam int DIR_BIT_L  = 5;
  localparam int DIR_BIT_R  = 4;
  localparam int DIR_BIT_UL = 3;
  localparam int DIR_BIT_UR = 2;
  localparam int DIR_BIT_DL = 1;
  localparam int DIR_BIT_DR = 0;

  localparam int ROW_STRIDE_DEF  = 10;
  localparam int BOARD_CELLS_DEF = 100;

`ifdef FLIP_DIAG_EN
  localparam int NUM_DIRS = 8;
`else
  localparam int NUM_DIRS = 4;
`endif

endpackage

`default_nettype wire

// File: rtl/flip_dir_step.sv
// =============================================================================
// Module  : flip_dir_step
// Purpose : Maps a direction index to its two's-complement address step.
//           Diagonal steps exist only when FLIP_DIAG_EN is defined.
// Revision: 1.0
// =============================================================================
`default_nettype none

import othello_pkg::*;

module flip_dir_step #(
  parameter int ADDR_W     = 7,
  parameter int ROW_STRIDE = ROW_STRIDE_DEF
) (
  input  dir_e               dir_i,
  output logic [ADDR_W-1:0]  step_o
);

  localparam logic [ADDR_W-1:0] STEP_U = ADDR_W'(-ROW_STRIDE);
  localparam logic [ADDR_W-1:0] STEP_D = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] STEP_L = ADDR_W'(-1);
  localparam logic [ADDR_W-1:0] STEP_R = ADDR_W'(1);
`ifdef FLIP_DIAG_EN
  localparam logic [ADDR_W-1:0] STEP_UL = ADDR_W'(-(ROW_STRIDE + 1));
  localparam logic [ADDR_W-1:0] STEP_UR = ADDR_W'(-(ROW_STRIDE - 1));
  localparam logic [ADDR_W-1:0] STEP_DL = ADDR_W'(ROW_STRIDE - 1);
  localparam logic [ADDR_W-1:0] STEP_DR = ADDR_W'(ROW_STRIDE + 1);
`endif

  always_comb begin
    step_o = '0;
    case (dir_i)
      DIR_U:   step_o = STEP_U;
      DIR_D:   step_o = STEP_D;
      DIR_L:   step_o = STEP_L;
      DIR_R:   step_o = STEP_R;
`ifdef FLIP_DIAG_EN
      DIR_UL:  step_o = STEP_UL;
      DIR_UR:  step_o = STEP_UR;
      DIR_DL:  step_o = STEP_DL;
      DIR_DR:  step_o = STEP_DR;
`endif
      default: step_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flip_sequencer.sv
// =============================================================================
// Module  : flip_sequencer
// Purpose : Writes the placed disc, then walks each flagged direction over the
//           board RAM flipping opponent runs. FLIP_DIAG_EN enables diagonals.
// Revision: 1.0
// =============================================================================
`default_nettype none

import othello_pkg::*;

module flip_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int ROW_STRIDE  = ROW_STRIDE_DEF,
  parameter int BOARD_CELLS = BOARD_CELLS_DEF,
  parameter int MAX_RUN     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] e_addr_i,
  input  logic              player_i,
  input  logic [7:0]        dir_mask_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_wdata_o,
  input  logic [1:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [5:0]        flip_count_o
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PLACE    = 3'd1;
  localparam logic [2:0] S_NEXT_DIR = 3'd2;
  localparam logic [2:0] S_RD       = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_WR       = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [ADDR_W:0]  CELLS_LIM = (ADDR_W + 1)'(BOARD_CELLS);
  localparam logic [3:0]       DIR_END   = 4'(NUM_DIRS);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_RUN);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] e_addr_q, e_addr_d;
  logic [1:0]        colour_q, colour_d;
  logic [7:0]        mask_q, mask_d;
  logic [3:0]        dir_q, dir_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [5:0]        flip_q, flip_d;

  logic [ADDR_W-1:0] step;
  logic              off_board;
  logic              dir_flagged;
  logic              is_opponent;

  flip_dir_step #(
    .ADDR_W     (ADDR_W),
    .ROW_STRIDE (ROW_STRIDE)
  ) u_step (
    .dir_i  (dir_e'(dir_q[2:0])),
    .step_o (step)
  );

  assign off_board   = {1'b0, cur_q} >= CELLS_LIM;
  assign dir_flagged = mask_q[3'd7 - dir_q[2:0]];
  assign is_opponent = (mem_rdata_i == ~colour_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      e_addr_q <= '0;
      colour_q <= '0;
      mask_q   <= '0;
      dir_q    <= '0;
      cur_q    <= '0;
      run_q    <= '0;
      flip_q   <= '0;
    end else begin
      state_q  <= state_d;
      e_addr_q <= e_addr_d;
      colour_q <= colour_d;
      mask_q   <= mask_d;
      dir_q    <= dir_d;
      cur_q    <= cur_d;
      run_q    <= run_d;
      flip_q   <= flip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    e_addr_d = e_addr_q;
    colour_d = colour_q;
    mask_d   = mask_q;
    dir_d    = dir_q;
    cur_d    = cur_q;
    run_d    = run_q;
    flip_d   = flip_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          e_addr_d = e_addr_i;
          colour_d = player_i ? CELL_WHITE : CELL_BLACK;
          mask_d   = dir_mask_i;
          flip_d   = '0;
          state_d  = S_PLACE;
        end
      end
      S_PLACE: begin
        if (mem_gnt_i) begin
          dir_d   = '0;
          state_d = S_NEXT_DIR;
        end
      end
      S_NEXT_DIR: begin
        if (dir_q == DIR_END) begin
          state_d = S_DONE;
        end else if (dir_flagged) begin
          cur_d   = e_addr_q + step;
          run_d   = '0;
          state_d = S_RD;
        end else begin
          dir_d = dir_q + 4'd1;
        end
      end
      S_RD: begin
        if (off_board) begin
          dir_d   = dir_q + 4'd1;
          state_d = S_NEXT_DIR;
        end else if (mem_gnt_i) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Runs are committed as read; closure is the validator's guarantee.
        if (is_opponent && (run_q < RUN_MAX)) begin
          state_d = S_WR;
        end else begin
          dir_d   = dir_q + 4'd1;
          state_d = S_NEXT_DIR;
        end
      end
      S_WR: begin
        if (mem_gnt_i) begin
          run_d   = run_q + RUN_W'(1);
          flip_d  = flip_q + 6'd1;
          cur_d   = cur_q + step;
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_PLACE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = e_addr_q;
        mem_wdata_o = colour_q;
      end
      S_RD: begin
        if (!off_board) begin
          mem_req_o   = 1'b1;
          mem_addr_o  = cur_q;
          mem_wdata_o = colour_q;
        end
      end
      S_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = cur_q;
        mem_wdata_o = colour_q;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
    busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o = (state_q == S_DONE);
  end

  assign flip_count_o = flip_q;

endmodule

`default_nettype wire

// File: tb/tb_flip_sequencer.sv
// =============================================================================
// Module  : tb_flip_sequencer
// Purpose : Randomised bench for flip_sequencer against a board-walk model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_flip_sequencer;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_i = 1'b0;
  logic [6:0] e_addr_i = '0;
  logic       player_i = 1'b0;
  logic [7:0] dir_mask_i = '0;
  logic       mem_req_o;
  logic       mem_gnt_i = 1'b0;
  logic       mem_we_o;
  logic [6:0] mem_addr_o;
  logic [1:0] mem_wdata_o;
  logic [1:0] mem_rdata_i = '0;
  logic       busy_o;
  logic       done_o;
  logic [5:0] flip_count_o;

  flip_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start_i      (start_i),
    .e_addr_i     (e_addr_i),
    .player_i     (player_i),
    .dir_mask_i   (dir_mask_i),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .flip_count_o (flip_count_o)
  );

  always #5 clock = ~clock;

`ifdef FLIP_DIAG_EN
  localparam int N_DIR = 8;
`else
  localparam int N_DIR = 4;
`endif

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [1:0] data;
  } acc_t;

  int total = 0;
  int bad = 0;

  logic [1:0] mem   [128];
  logic [1:0] board [128];
  acc_t dut_log[$];
  acc_t exp_log[$];
  int   exp_flips;
  int   stab_err = 0;
  bit   pend_valid = 0;
  acc_t pend_acc;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: service the RAM at the edge, present read data afterwards.
  task automatic tick();
    acc_t cur;
    bit   rd_pend;
    logic [1:0] rd_val;
    rd_pend = 0;
    rd_val  = '0;
    @(posedge clock);
    cur = '{mem_we_o, mem_addr_o, mem_wdata_o};
    if (pend_valid && (!mem_req_o || cur != pend_acc)) stab_err++;
    pend_valid = mem_req_o && !mem_gnt_i;
    pend_acc   = cur;
    if (mem_req_o && mem_gnt_i) begin
      dut_log.push_back(cur);
      if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
      else begin
        rd_pend = 1;
        rd_val  = mem[mem_addr_o];
      end
    end
    @(negedge clock);
    mem_rdata_i = rd_pend ? rd_val : 2'($urandom);
  endtask

  function automatic int step_of(input int d);
    case (d)
      0: return -10;
      1: return 10;
      2: return -1;
      3: return 1;
      4: return -11;
      5: return -9;
      6: return 9;
      default: return 11;
    endcase
  endfunction

  // Reference walk over a copy of the board.
  task automatic model(input int e, input bit pl, input logic [7:0] mask);
    logic [1:0] own, opp;
    own = pl ? 2'b10 : 2'b01;
    opp = ~own;
    board = mem;
    exp_log.delete();
    exp_flips = 0;
    board[e] = own;
    exp_log.push_back('{1'b1, 7'(e), own});
    for (int d = 0; d < N_DIR; d++) begin
      if (mask[7-d]) begin
        int pos = (e + step_of(d)) & 127;
        int run = 0;
        while (pos < 100) begin
          exp_log.push_back('{1'b0, 7'(pos), 2'b00});
          if (board[pos] == opp && run < 6) begin
            board[pos] = own;
            exp_log.push_back('{1'b1, 7'(pos), own});
            run++;
            exp_flips++;
            pos = (pos + step_of(d)) & 127;
          end else break;
        end
      end
    end
  endtask

  task automatic gen_board(input bit rnd);
    for (int a = 0; a < 128; a++) begin
      int r = a / 10;
      int c = a % 10;
      if (a >= 100 || r == 0 || r == 9 || c == 0 || c == 9) mem[a] = 2'b11;
      else if (!rnd) mem[a] = 2'b00;
      else mem[a] = ($urandom_range(0, 5) == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
    end
  endtask

  // gmode: 0 always granted, 1 random grant, 2 five-cycle stall on first flip write
  task automatic run_move(input string tag, input int e, input bit pl, input logic [7:0] mask,
                          input int gmode, input bit noise);
    bit seen;
    bit stall_armed;
    int stall_left;
    int nbad;
    int diff;
    int stab0;
    model(e, pl, mask);
    dut_log.delete();
    stab0 = stab_err;
    e_addr_i   = 7'(e);
    player_i   = pl;
    dir_mask_i = mask;
    start_i    = 1'b1;
    mem_gnt_i  = (gmode != 1) ? 1'b1 : 1'($urandom);
    tick();
    start_i    = 1'b0;
    e_addr_i   = 7'($urandom);
    player_i   = 1'($urandom);
    dir_mask_i = 8'($urandom);
    check_eq({tag, " busy"}, int'(busy_o), 1);
    seen = 0;
    stall_armed = (gmode == 2);
    stall_left = 0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (gmode == 0) mem_gnt_i = 1'b1;
      else if (gmode == 1) mem_gnt_i = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0) begin
        mem_gnt_i = 1'b0;
        stall_left--;
      end else if (stall_armed && mem_req_o && mem_we_o && mem_addr_o != 7'(e)) begin
        stall_armed = 0;
        mem_gnt_i = 1'b0;
        stall_left = 4;
      end else mem_gnt_i = 1'b1;
      start_i = noise && busy_o && ($urandom_range(0, 7) == 0);
      tick();
      if (done_o) seen = 1;
    end
    start_i = 1'b0;
    check_eq({tag, " done"}, int'(seen), 1);
    check_eq({tag, " busy_at_done"}, int'(busy_o), 0);
    check_eq({tag, " flips"}, int'(flip_count_o), exp_flips);
    check_eq({tag, " n_access"}, dut_log.size(), exp_log.size());
    nbad = 0;
    for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++) begin
      acc_t a = dut_log[i];
      acc_t b = exp_log[i];
      if (a.we !== b.we || a.addr !== b.addr || (b.we && a.data !== b.data)) nbad++;
    end
    check_eq({tag, " access_seq"}, nbad, 0);
    diff = 0;
    for (int a = 0; a < 128; a++) if (mem[a] !== board[a]) diff++;
    check_eq({tag, " board"}, diff, 0);
    check_eq({tag, " stable"}, stab_err - stab0, 0);
    if (gmode == 2) check_eq({tag, " stall_hit"}, int'(stall_armed), 0);
    mem_gnt_i = 1'b0;
    tick();
    check_eq({tag, " done_pulse"}, int'(done_o), 0);
    check_eq({tag, " flips_hold"}, int'(flip_count_o), exp_flips);
    if (!seen) begin
      reset = 1'b0;
      tick();
      reset = 1'b1;
      pend_valid = 0;
    end
  endtask

  initial begin
    bit hit;
    gen_board(0);
    tick();
    tick();
    check_eq("rst req", int'(mem_req_o), 0);
    check_eq("rst busy", int'(busy_o), 0);
    check_eq("rst done", int'(done_o), 0);
    check_eq("rst flips", int'(flip_count_o), 0);
    check_eq("rst addr", int'(mem_addr_o), 0);
    check_eq("rst we", int'(mem_we_o), 0);
    reset = 1'b1;
    tick();

    gen_board(0);
    mem[45] = 2'b10; mem[35] = 2'b10; mem[25] = 2'b01;
    run_move("up_run", 55, 0, 8'h80, 0, 0);
    check_eq("up_run count", int'(flip_count_o), 2);

    gen_board(0);
    run_move("no_dirs", 37, 1, 8'h00, 1, 0);

    gen_board(0);
    mem[45] = 2'b10; mem[35] = 2'b10; mem[25] = 2'b01;
    run_move("stall", 55, 0, 8'h80, 2, 0);

    gen_board(0);
    run_move("corner", 11, 0, 8'hA0, 0, 0);

    gen_board(1);
    mem[22] = 2'b00; mem[33] = 2'b10; mem[44] = 2'b01;
    run_move("diag_dr", 22, 0, 8'h0F, 0, 0);

    // Abort in the middle of a run, then a clean move on the surviving board.
    gen_board(0);
    mem[45] = 2'b10; mem[35] = 2'b10; mem[25] = 2'b10; mem[15] = 2'b01;
    e_addr_i = 7'd55; player_i = 0; dir_mask_i = 8'h80; start_i = 1'b1; mem_gnt_i = 1'b1;
    tick();
    start_i = 1'b0;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (mem_req_o && mem_we_o && mem_addr_o != 7'd55) hit = 1;
      else tick();
    end
    check_eq("abort reached_wr", int'(hit), 1);
    reset = 1'b0;
    #1;
    check_eq("abort req", int'(mem_req_o), 0);
    check_eq("abort busy", int'(busy_o), 0);
    check_eq("abort flips", int'(flip_count_o), 0);
    pend_valid = 0;
    tick();
    check_eq("abort hold", int'(mem_req_o), 0);
    reset = 1'b1;
    tick();
    run_move("after_abort", 55, 0, 8'h80, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int r = $urandom_range(1, 8);
      int c = $urandom_range(1, 8);
      gen_board(1);
      run_move($sformatf("rnd%0d", n), r * 10 + c, 1'($urandom), 8'($urandom),
               $urandom_range(0, 1), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
